regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 16: register data width.
REQ-002 Parameter ADDR_WIDTH, default 3: register address width; register count is 2**ADDR_WIDTH (8).
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 alu_valid  in  1  ALU writeback request.
REQ-006 alu_address  in  ADDR_WIDTH  ALU destination register.
REQ-007 alu_data  in  DATA_WIDTH  ALU result.
REQ-008 alu_ready  out  1  ALU request accepted this cycle.
REQ-009 mem_valid  in  1  load writeback request.
REQ-010 mem_address  in  ADDR_WIDTH  load destination register.
REQ-011 mem_data  in  DATA_WIDTH  load data.
REQ-012 mem_ready  out  1  load request accepted this cycle.
REQ-013 reserve_valid  in  1  load issued; reserve destination register.
REQ-014 reserve_address  in  ADDR_WIDTH  register to reserve.
REQ-015 register_write  out  1  write enable to register file.
REQ-016 write_address  out  ADDR_WIDTH  register file write address.
REQ-017 write_data  out  DATA_WIDTH  register file write data.
REQ-018 busy  out  2**ADDR_WIDTH  per-register pending-load bits.
REQ-019 conflict_count  out  8  saturating count of cycles with both requests valid.

Function
REQ-020 At most one of alu_ready/mem_ready SHALL be high in any cycle; ready is combinational from valid, busy and arbitration state.
REQ-021 A transfer SHALL occur when valid and ready are both high; requesters hold valid, address and data stable until ready.
REQ-022 ALU eligibility SHALL require alu_valid=1 and busy[alu_address]=0 (WAW ordering behind pending load); mem eligibility SHALL require mem_valid=1 only.
REQ-023 Exactly one eligible requester SHALL be granted.
REQ-024 Both eligible: grant SHALL go to the requester not granted last (round-robin); last_grant updates only on a transfer.
REQ-025 A transfer in cycle N SHALL produce register_write=1 with the latched address/data in cycle N+1 (latency 1); otherwise register_write=0 and write_address/write_data hold their last values.
REQ-026 reserve_valid=1 in cycle N SHALL set busy[reserve_address] in cycle N+1.
REQ-027 A mem transfer in cycle N SHALL clear busy[mem_address] in cycle N+1.
REQ-028 Set and clear of the same bit in the same cycle: set SHALL win.
REQ-029 Register 0 (BA) SHALL be treated identically to all other registers.
REQ-030 conflict_count SHALL increment on each cycle with alu_valid=1 and mem_valid=1, saturating at 255.

Reset
REQ-031 rst=1 SHALL force register_write=0, write_address=0, write_data=0, busy=0, conflict_count=0, last_grant=mem (ALU wins first tie).
REQ-032 rst=1 SHALL force alu_ready=0 and mem_ready=0 in that cycle; a transfer in the cycle preceding reset SHALL be discarded (register_write=0 during and after reset).

Structure
REQ-033 Package regfile_pkg SHALL hold DATA_WIDTH/ADDR_WIDTH defaults, REG_COUNT and the grant-source enum (SRC_ALU, SRC_MEM).
REQ-034 Sub-module regfile_scoreboard SHALL hold busy bits and set/clear logic (REQ-026..028); arbitration and output stage stay in the top.

Verification
REQ-035 Reset, then alu_valid=1 addr 5 data 16'h1234 -> alu_ready=1 same cycle; next cycle register_write=1, write_address=5, write_data=16'h1234.
REQ-036 Both valid for 4 cycles (ALU addr 4, mem addr 6) -> grants ALU, mem, ALU, mem; conflict_count=4.
REQ-037 reserve addr 3; next cycle alu_valid addr 3 -> alu_ready=0 until mem transfer addr 3 data 16'hFFFD; ALU accepted the cycle after busy[3] clears; write order mem then ALU.
REQ-038 reserve_valid addr 2 in the same cycle as a mem transfer addr 2 -> busy[2]=1 afterwards.
REQ-039 Both valid held 300 cycles -> conflict_count saturates at 255.
REQ-040 rst asserted the cycle after a transfer -> register_write=0, busy=0, conflict_count=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and grant-source encoding for the register file write arbiter.
package regfile_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 16;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 3;
  localparam int unsigned REG_COUNT          = 2 ** DEFAULT_ADDR_WIDTH;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-load bits: set on load issue, cleared on load writeback, set wins.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         set_valid,
  input  logic [ADDR_WIDTH-1:0]        set_address,
  input  logic                         clr_valid,
  input  logic [ADDR_WIDTH-1:0]        clr_address,
  output logic [(2**ADDR_WIDTH)-1:0]   busy
);

  logic [(2**ADDR_WIDTH)-1:0] busy_d;

  // Clear applied first so a same-cycle reservation of the same register survives.
  always_comb begin
    busy_d = busy;
    if (clr_valid) busy_d[clr_address] = 1'b0;
    if (set_valid) busy_d[set_address] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_d;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates ALU and load writebacks onto a single register file write port,
// holding ALU writes behind pending loads to the same register.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_valid,
  input  logic [ADDR_WIDTH-1:0]        alu_address,
  input  logic [DATA_WIDTH-1:0]        alu_data,
  output logic                         alu_ready,
  input  logic                         mem_valid,
  input  logic [ADDR_WIDTH-1:0]        mem_address,
  input  logic [DATA_WIDTH-1:0]        mem_data,
  output logic                         mem_ready,
  input  logic                         reserve_valid,
  input  logic [ADDR_WIDTH-1:0]        reserve_address,
  output logic                         register_write,
  output logic [ADDR_WIDTH-1:0]        write_address,
  output logic [DATA_WIDTH-1:0]        write_data,
  output logic [(2**ADDR_WIDTH)-1:0]   busy,
  output logic [7:0]                   conflict_count
);

  src_e last_grant;
  src_e last_grant_d;
  logic alu_elig;
  logic mem_elig;
  logic write_q;

  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .set_valid   (reserve_valid),
    .set_address (reserve_address),
    .clr_valid   (mem_ready),
    .clr_address (mem_address),
    .busy        (busy)
  );

  // Grant selection: single eligible requester wins, ties alternate.
  always_comb begin
    alu_ready    = 1'b0;
    mem_ready    = 1'b0;
    last_grant_d = last_grant;
    alu_elig     = alu_valid && !busy[alu_address];
    mem_elig     = mem_valid;
    if (!rst) begin
      if (alu_elig && mem_elig) begin
        if (last_grant == SRC_MEM) alu_ready = 1'b1;
        else                       mem_ready = 1'b1;
      end else if (alu_elig) begin
        alu_ready = 1'b1;
      end else if (mem_elig) begin
        mem_ready = 1'b1;
      end
    end
    if (alu_ready)      last_grant_d = SRC_ALU;
    else if (mem_ready) last_grant_d = SRC_MEM;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant     <= SRC_MEM;
      write_q        <= 1'b0;
      write_address  <= '0;
      write_data     <= '0;
      conflict_count <= '0;
    end else begin
      last_grant <= last_grant_d;
      write_q    <= alu_ready || mem_ready;
      if (alu_ready) begin
        write_address <= alu_address;
        write_data    <= alu_data;
      end else if (mem_ready) begin
        write_address <= mem_address;
        write_data    <= mem_data;
      end
      if (alu_valid && mem_valid && (conflict_count != 8'hFF))
        conflict_count <= conflict_count + 8'd1;
    end
  end

  // A write latched just before reset must never reach the register file.
  assign register_write = write_q && !rst;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_regfile_write_arbiter;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 3;
  localparam int unsigned NR = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid;
  logic [AW-1:0] alu_address;
  logic [DW-1:0] alu_data;
  logic          alu_ready;
  logic          mem_valid;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data;
  logic          mem_ready;
  logic          reserve_valid;
  logic [AW-1:0] reserve_address;
  logic          register_write;
  logic [AW-1:0] write_address;
  logic [DW-1:0] write_data;
  logic [NR-1:0] busy;
  logic [7:0]    conflict_count;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  bit          m_busy [NR];
  bit          m_alu_next;
  int          m_cc;
  bit          m_wr;
  int unsigned m_wa;
  int unsigned m_wd;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .rst             (rst),
    .alu_valid       (alu_valid),
    .alu_address     (alu_address),
    .alu_data        (alu_data),
    .alu_ready       (alu_ready),
    .mem_valid       (mem_valid),
    .mem_address     (mem_address),
    .mem_data        (mem_data),
    .mem_ready       (mem_ready),
    .reserve_valid   (reserve_valid),
    .reserve_address (reserve_address),
    .register_write  (register_write),
    .write_address   (write_address),
    .write_data      (write_data),
    .busy            (busy),
    .conflict_count  (conflict_count)
  );

  function automatic void model_grant(output bit ar, output bit mr);
    bit alu_ok;
    ar = 0;
    mr = 0;
    alu_ok = alu_valid && !m_busy[int'(alu_address)];
    if (!rst) begin
      if (alu_ok && mem_valid) begin
        ar = m_alu_next;
        mr = !m_alu_next;
      end else begin
        ar = alu_ok;
        mr = mem_valid;
      end
    end
  endfunction

  function automatic logic [NR-1:0] model_busy_vec();
    logic [NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_edge();
    bit ar, mr;
    model_grant(ar, mr);
    if (rst) begin
      foreach (m_busy[i]) m_busy[i] = 0;
      m_alu_next = 1;
      m_cc = 0;
      m_wr = 0;
      m_wa = 0;
      m_wd = 0;
    end else begin
      m_wr = ar || mr;
      if (ar) begin m_wa = alu_address; m_wd = alu_data; end
      if (mr) begin m_wa = mem_address; m_wd = mem_data; end
      if (mr) m_busy[int'(mem_address)] = 0;
      if (reserve_valid) m_busy[int'(reserve_address)] = 1;
      if (alu_valid && mem_valid) m_cc = (m_cc >= 255) ? 255 : m_cc + 1;
      if (ar) m_alu_next = 0;
      if (mr) m_alu_next = 1;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_address = '0; alu_data = '0;
    mem_valid = 0; mem_address = '0; mem_data = '0;
    reserve_valid = 0; reserve_address = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    alu_valid = 1; mem_valid = 1;
    #1;
    checks++;
    if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: alu=%b mem=%b want 0 0", alu_ready, mem_ready);
    end
    checks++;
    if (register_write !== 1'b0 || write_address !== 3'd0 || write_data !== 16'h0) begin
      errors++; $display("FAIL reset_write: we=%b wa=%0d wd=%h want 0 0 0", register_write, write_address, write_data);
    end
    checks++;
    if (busy !== 8'h00 || conflict_count !== 8'd0) begin
      errors++; $display("FAIL reset_state: busy=%h cc=%0d want 00 0", busy, conflict_count);
    end
    idle_inputs();
    rst = 0;
  endtask

  task automatic test_alu_single();
    do_reset();
    alu_valid = 1; alu_address = 3'd5; alu_data = 16'h1234;
    #1;
    checks++;
    if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
      errors++; $display("FAIL alu_single_ready: alu=%b mem=%b want 1 0", alu_ready, mem_ready);
    end
    tick();
    alu_valid = 0;
    #1;
    checks++;
    if (register_write !== 1'b1 || write_address !== 3'd5 || write_data !== 16'h1234) begin
      errors++; $display("FAIL alu_single_write: we=%b wa=%0d wd=%h want 1 5 1234", register_write, write_address, write_data);
    end
    tick();
    checks++;
    if (register_write !== 1'b0 || write_address !== 3'd5 || write_data !== 16'h1234) begin
      errors++; $display("FAIL alu_single_hold: we=%b wa=%0d wd=%h want 0 5 1234", register_write, write_address, write_data);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    alu_valid = 1; alu_address = 3'd4; alu_data = 16'hA4A4;
    mem_valid = 1; mem_address = 3'd6; mem_data = 16'h6666;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (alu_ready !== (i % 2 == 0) || mem_ready !== (i % 2 == 1)) begin
        errors++; $display("FAIL rr_grant%0d: alu=%b mem=%b want %b %b", i, alu_ready, mem_ready, i % 2 == 0, i % 2 == 1);
      end
      if (i > 0) begin
        checks++;
        if (register_write !== 1'b1 || write_address !== ((i % 2 == 1) ? 3'd4 : 3'd6)) begin
          errors++; $display("FAIL rr_write%0d: we=%b wa=%0d", i, register_write, write_address);
        end
      end
      tick();
    end
    idle_inputs();
    #1;
    checks++;
    if (conflict_count !== 8'd4 || write_address !== 3'd6 || write_data !== 16'h6666) begin
      errors++; $display("FAIL rr_count: cc=%0d wa=%0d wd=%h want 4 6 6666", conflict_count, write_address, write_data);
    end
  endtask

  task automatic test_waw_hold();
    do_reset();
    reserve_valid = 1; reserve_address = 3'd3;
    tick();
    reserve_valid = 0;
    alu_valid = 1; alu_address = 3'd3; alu_data = 16'hAAAA;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (alu_ready !== 1'b0 || busy[3] !== 1'b1) begin
        errors++; $display("FAIL waw_block%0d: alu_ready=%b busy3=%b want 0 1", i, alu_ready, busy[3]);
      end
      tick();
    end
    mem_valid = 1; mem_address = 3'd3; mem_data = 16'hFFFD;
    #1;
    checks++;
    if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin
      errors++; $display("FAIL waw_mem_grant: mem=%b alu=%b want 1 0", mem_ready, alu_ready);
    end
    tick();
    mem_valid = 0;
    #1;
    checks++;
    if (register_write !== 1'b1 || write_address !== 3'd3 || write_data !== 16'hFFFD || busy[3] !== 1'b0 || alu_ready !== 1'b1) begin
      errors++; $display("FAIL waw_mem_write: we=%b wa=%0d wd=%h busy3=%b alu_ready=%b want 1 3 fffd 0 1",
                         register_write, write_address, write_data, busy[3], alu_ready);
    end
    tick();
    alu_valid = 0;
    #1;
    checks++;
    if (register_write !== 1'b1 || write_address !== 3'd3 || write_data !== 16'hAAAA) begin
      errors++; $display("FAIL waw_alu_write: we=%b wa=%0d wd=%h want 1 3 aaaa", register_write, write_address, write_data);
    end
  endtask

  task automatic test_set_wins();
    do_reset();
    reserve_valid = 1; reserve_address = 3'd2;
    tick();
    mem_valid = 1; mem_address = 3'd2; mem_data = 16'h0202;
    #1;
    checks++;
    if (mem_ready !== 1'b1) begin
      errors++; $display("FAIL set_wins_grant: mem_ready=%b want 1", mem_ready);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (busy !== 8'h04 || register_write !== 1'b1 || write_data !== 16'h0202) begin
      errors++; $display("FAIL set_wins_busy: busy=%h we=%b wd=%h want 04 1 0202", busy, register_write, write_data);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    alu_valid = 1; alu_address = 3'd0; alu_data = 16'h0BA0;
    mem_valid = 1; mem_address = 3'd0; mem_data = 16'h0BA1;
    for (int i = 0; i < 300; i++) begin
      if (i == 255) begin
        checks++;
        if (conflict_count !== 8'd255) begin
          errors++; $display("FAIL sat_reach: cc=%0d want 255", conflict_count);
        end
      end
      tick();
    end
    idle_inputs();
    #1;
    checks++;
    if (conflict_count !== 8'd255) begin
      errors++; $display("FAIL sat_hold: cc=%0d want 255", conflict_count);
    end
  endtask

  task automatic test_reset_after_transfer();
    do_reset();
    alu_valid = 1; alu_address = 3'd1; alu_data = 16'h0055;
    mem_valid = 1; mem_address = 3'd0; mem_data = 16'h00AA;
    reserve_valid = 1; reserve_address = 3'd7;
    tick();
    idle_inputs();
    rst = 1;
    #1;
    checks++;
    if (register_write !== 1'b0) begin
      errors++; $display("FAIL rst_after_xfer_during: we=%b want 0", register_write);
    end
    tick();
    rst = 0;
    #1;
    checks++;
    if (register_write !== 1'b0 || busy !== 8'h00 || conflict_count !== 8'd0 || write_address !== 3'd0 || write_data !== 16'h0) begin
      errors++; $display("FAIL rst_after_xfer_after: we=%b busy=%h cc=%0d wa=%0d wd=%h want 0 00 0 0 0",
                         register_write, busy, conflict_count, write_address, write_data);
    end
  endtask

  task automatic test_random();
    bit ar, mr, prev_ar, prev_mr;
    do_reset();
    prev_ar = 0; prev_mr = 0;
    for (int i = 0; i < 600; i++) begin
      if (!alu_valid || prev_ar || rst) begin
        alu_valid = $urandom_range(0, 1) == 1;
        alu_address = AW'($urandom);
        alu_data = DW'($urandom);
      end
      if (!mem_valid || prev_mr || rst) begin
        mem_valid = $urandom_range(0, 2) == 0;
        mem_address = AW'($urandom);
        mem_data = DW'($urandom);
      end
      reserve_valid = $urandom_range(0, 2) == 0;
      reserve_address = AW'($urandom);
      rst = $urandom_range(0, 49) == 0;
      #1;
      model_grant(ar, mr);
      checks++;
      if (alu_ready !== ar || mem_ready !== mr) begin
        errors++; $display("FAIL rand_ready@%0d: alu=%b mem=%b want %b %b", i, alu_ready, mem_ready, ar, mr);
      end
      checks++;
      if (register_write !== (m_wr && !rst) || write_address !== AW'(m_wa) || write_data !== DW'(m_wd)) begin
        errors++; $display("FAIL rand_write@%0d: we=%b wa=%0d wd=%h want %b %0d %h",
                           i, register_write, write_address, write_data, m_wr && !rst, m_wa, m_wd);
      end
      checks++;
      if (busy !== model_busy_vec() || conflict_count !== 8'(m_cc)) begin
        errors++; $display("FAIL rand_state@%0d: busy=%h cc=%0d want %h %0d", i, busy, conflict_count, model_busy_vec(), m_cc);
      end
      prev_ar = ar; prev_mr = mr;
      tick();
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    #1;
    test_reset();
    test_alu_single();
    test_round_robin();
    test_waw_hold();
    test_set_wins();
    test_saturate();
    test_reset_after_transfer();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
